// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from EXE, waits for the
// data-SRAM response on loads, aligns load data and hands the result to WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_valid_in,
  output logic        mem_allowin_out,
  input  logic [31:0] exe_PC_in,
  input  logic [31:0] exe_alures_in,
  input  logic [3:0]  exe_reg_we_in,
  input  logic [4:0]  exe_wnum_in,
  input  logic [2:0]  exe_load_type_in,
  input  logic [2:0]  exe_write_type_in,
  input  logic [31:0] data_rdata_in,
  input  logic        data_data_ok_in,
  input  logic        wb_allowin_in,
  output logic        mem_valid_out,
  output logic [31:0] mem_PC_out,
  output logic [31:0] mem_wbdata_out,
  output logic [3:0]  mem_reg_we_out,
  output logic [4:0]  mem_wnum_out,
  output logic [2:0]  mem_write_type_out,
  output logic [4:0]  mem_fwd_wnum_out,
  output logic        mem_fwd_busy_out
);

  typedef enum logic [2:0] {
    LD_NONE = 3'd0, LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3,
    LD_LHU  = 3'd4, LD_LW = 3'd5, LD_LWL = 3'd6, LD_LWR = 3'd7
  } load_e;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_alures;
  logic [3:0]  r_reg_we;
  logic [4:0]  r_wnum;
  load_e       r_load_type;
  logic [2:0]  r_write_type;
  logic        r_got;
  logic [31:0] r_rbuf;

  logic        w_is_load;
  logic        w_ready;
  logic        w_enter;
  logic        w_leave;
  logic [31:0] w_rdata;
  logic [1:0]  w_a;
  logic [31:0] w_shr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wbdata;
  logic [3:0]  w_mask;

  // Handshake: an instruction moves EXE->MEM on an edge where exe_valid_in and
  // mem_allowin_out are both high, and MEM->WB where mem_valid_out and
  // wb_allowin_in are both high; valid never depends on the receiver's allowin.
  assign w_is_load       = (r_load_type != LD_NONE);
  assign w_ready         = !w_is_load || r_got || data_data_ok_in;
  assign mem_allowin_out = !r_valid || (w_ready && wb_allowin_in);
  assign mem_valid_out   = r_valid && w_ready;
  assign w_enter         = mem_allowin_out && exe_valid_in;
  assign w_leave         = mem_valid_out && wb_allowin_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= 32'd0;
      r_alures     <= 32'd0;
      r_reg_we     <= 4'd0;
      r_wnum       <= 5'd0;
      r_load_type  <= LD_NONE;
      r_write_type <= 3'd0;
    end else begin
      if (mem_allowin_out) r_valid <= exe_valid_in;
      if (w_enter) begin
        r_pc         <= exe_PC_in;
        r_alures     <= exe_alures_in;
        r_reg_we     <= exe_reg_we_in;
        r_wnum       <= exe_wnum_in;
        r_load_type  <= load_e'(exe_load_type_in);
        r_write_type <= exe_write_type_in;
      end
    end
  end

  // The buffer holds the response once WB stalls, so later bus data is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_got  <= 1'b0;
      r_rbuf <= 32'd0;
    end else if (w_enter || w_leave) begin
      r_got <= 1'b0;
    end else if (r_valid && w_is_load && !r_got && data_data_ok_in) begin
      r_got  <= 1'b1;
      r_rbuf <= data_rdata_in;
    end
  end

  assign w_rdata = r_got ? r_rbuf : data_rdata_in;
  assign w_a     = r_alures[1:0];
  assign w_shr   = w_rdata >> {w_a, 3'b000};
  assign w_byte  = w_shr[7:0];
  assign w_half  = w_a[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_wbdata = r_alures;
    w_mask   = 4'b1111;
    case (r_load_type)
      LD_LB:  w_wbdata = {{24{w_byte[7]}}, w_byte};
      LD_LBU: w_wbdata = {24'd0, w_byte};
      LD_LH:  w_wbdata = {{16{w_half[15]}}, w_half};
      LD_LHU: w_wbdata = {16'd0, w_half};
      LD_LW:  w_wbdata = w_rdata;
      LD_LWL: begin
        w_wbdata = w_rdata << {~w_a, 3'b000};
        w_mask   = 4'b1111 << (~w_a);
      end
      LD_LWR: begin
        w_wbdata = w_shr;
        w_mask   = 4'b1111 >> w_a;
      end
      default: begin
        w_wbdata = r_alures;
        w_mask   = 4'b1111;
      end
    endcase
  end

  assign mem_PC_out         = r_pc;
  assign mem_wbdata_out     = w_wbdata;
  assign mem_write_type_out = r_write_type;
  assign mem_reg_we_out     = r_reg_we & w_mask & {4{mem_valid_out}};
  assign mem_wnum_out       = r_wnum & {5{mem_valid_out}};
  assign mem_fwd_wnum_out   = r_wnum & {5{r_valid}};
  assign mem_fwd_busy_out   = r_valid && w_is_load && !r_got && !data_data_ok_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs are
// checked 1ns later, and the stage captures on the rising edge.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        exe_valid_in;
  logic        mem_allowin_out;
  logic [31:0] exe_PC_in;
  logic [31:0] exe_alures_in;
  logic [3:0]  exe_reg_we_in;
  logic [4:0]  exe_wnum_in;
  logic [2:0]  exe_load_type_in;
  logic [2:0]  exe_write_type_in;
  logic [31:0] data_rdata_in;
  logic        data_data_ok_in;
  logic        wb_allowin_in;
  logic        mem_valid_out;
  logic [31:0] mem_PC_out;
  logic [31:0] mem_wbdata_out;
  logic [3:0]  mem_reg_we_out;
  logic [4:0]  mem_wnum_out;
  logic [2:0]  mem_write_type_out;
  logic [4:0]  mem_fwd_wnum_out;
  logic        mem_fwd_busy_out;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid_in(exe_valid_in), .mem_allowin_out(mem_allowin_out),
    .exe_PC_in(exe_PC_in), .exe_alures_in(exe_alures_in),
    .exe_reg_we_in(exe_reg_we_in), .exe_wnum_in(exe_wnum_in),
    .exe_load_type_in(exe_load_type_in), .exe_write_type_in(exe_write_type_in),
    .data_rdata_in(data_rdata_in), .data_data_ok_in(data_data_ok_in),
    .wb_allowin_in(wb_allowin_in), .mem_valid_out(mem_valid_out),
    .mem_PC_out(mem_PC_out), .mem_wbdata_out(mem_wbdata_out),
    .mem_reg_we_out(mem_reg_we_out), .mem_wnum_out(mem_wnum_out),
    .mem_write_type_out(mem_write_type_out), .mem_fwd_wnum_out(mem_fwd_wnum_out),
    .mem_fwd_busy_out(mem_fwd_busy_out)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive_exe(input logic [31:0] pc, input logic [31:0] alures,
                           input logic [3:0] we, input logic [4:0] wnum,
                           input logic [2:0] ltype, input logic [2:0] wtype);
    exe_valid_in      = 1'b1;
    exe_PC_in         = pc;
    exe_alures_in     = alures;
    exe_reg_we_in     = we;
    exe_wnum_in       = wnum;
    exe_load_type_in  = ltype;
    exe_write_type_in = wtype;
  endtask

  task automatic idle_exe();
    exe_valid_in      = 1'b0;
    exe_PC_in         = 32'd0;
    exe_alures_in     = 32'd0;
    exe_reg_we_in     = 4'd0;
    exe_wnum_in       = 5'd0;
    exe_load_type_in  = 3'd0;
    exe_write_type_in = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0; idle_exe(); data_rdata_in = 32'd0; data_data_ok_in = 1'b0; wb_allowin_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", mem_valid_out); end
    checks++; if (mem_PC_out !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", mem_PC_out); end
    checks++; if (mem_wbdata_out !== 32'd0) begin errors++; $display("FAIL rst_wbdata got %h exp 0", mem_wbdata_out); end
    checks++; if (mem_fwd_wnum_out !== 5'd0) begin errors++; $display("FAIL rst_fwd_wnum got %h exp 0", mem_fwd_wnum_out); end
    rst_n = 1'b1;
    #1;
    checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0h exp 1", mem_allowin_out); end
    checks++; if (mem_fwd_busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", mem_fwd_busy_out); end
  endtask

  task automatic test_add();
    @(negedge clk);
    drive_exe(32'hBFC0_0010, 32'h1234_5678, 4'b1111, 5'd5, 3'd0, 3'd3);
    step();
    idle_exe();
    #1;
    checks++; if (mem_valid_out !== 1'b1) begin errors++; $display("FAIL add_valid got %0h exp 1", mem_valid_out); end
    checks++; if (mem_wbdata_out !== 32'h1234_5678) begin errors++; $display("FAIL add_wbdata got %h exp 12345678", mem_wbdata_out); end
    checks++; if (mem_reg_we_out !== 4'b1111) begin errors++; $display("FAIL add_we got %b exp 1111", mem_reg_we_out); end
    checks++; if (mem_wnum_out !== 5'd5) begin errors++; $display("FAIL add_wnum got %0d exp 5", mem_wnum_out); end
    checks++; if (mem_PC_out !== 32'hBFC0_0010) begin errors++; $display("FAIL add_pc got %h exp bfc00010", mem_PC_out); end
    checks++; if (mem_write_type_out !== 3'd3) begin errors++; $display("FAIL add_wtype got %0d exp 3", mem_write_type_out); end
    checks++; if (mem_fwd_busy_out !== 1'b0) begin errors++; $display("FAIL add_busy got %0h exp 0", mem_fwd_busy_out); end
    step();
    #1;
    checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0h exp 0", mem_valid_out); end
    checks++; if (mem_reg_we_out !== 4'b0000) begin errors++; $display("FAIL bubble_we got %b exp 0000", mem_reg_we_out); end
    checks++; if (mem_wnum_out !== 5'd0) begin errors++; $display("FAIL bubble_wnum got %0d exp 0", mem_wnum_out); end
  endtask

  // Load alignment table: type, address, read data, expected data and enables.
  task automatic test_load_align();
    logic [2:0]  lt  [6] = '{3'd1, 3'd2, 3'd6, 3'd7, 3'd3, 3'd4};
    logic [31:0] ad  [6] = '{32'h1000_0001, 32'h1000_0001, 32'h1000_0001, 32'h1000_0002, 32'h1000_0002, 32'h1000_0000};
    logic [31:0] rd  [6] = '{32'h0080_FF00, 32'h0080_FF00, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'h8001_7FFF, 32'h8001_9234};
    logic [31:0] exd [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hCCDD_0000, 32'h0000_AABB, 32'hFFFF_8001, 32'h0000_9234};
    logic [3:0]  exw [6] = '{4'b1111, 4'b1111, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      drive_exe(32'h100 + 32'(i * 4), ad[i], 4'b1111, 5'd3, lt[i], 3'd0);
      step();
      idle_exe();
      #1;
      checks++; if (mem_fwd_busy_out !== 1'b1) begin errors++; $display("FAIL align%0d_busy got %0h exp 1", i, mem_fwd_busy_out); end
      checks++; if (mem_allowin_out !== 1'b0) begin errors++; $display("FAIL align%0d_allowin got %0h exp 0", i, mem_allowin_out); end
      data_data_ok_in = 1'b1; data_rdata_in = rd[i];
      #1;
      checks++; if (mem_valid_out !== 1'b1) begin errors++; $display("FAIL align%0d_valid got %0h exp 1", i, mem_valid_out); end
      checks++; if (mem_wbdata_out !== exd[i]) begin errors++; $display("FAIL align%0d_data got %h exp %h", i, mem_wbdata_out, exd[i]); end
      checks++; if (mem_reg_we_out !== exw[i]) begin errors++; $display("FAIL align%0d_we got %b exp %b", i, mem_reg_we_out, exw[i]); end
      step();
      data_data_ok_in = 1'b0;
    end
  endtask

  task automatic test_load_delay();
    drive_exe(32'h200, 32'h2000_0000, 4'b1111, 5'd12, 3'd5, 3'd0);
    step();
    idle_exe();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({mem_fwd_busy_out, mem_valid_out, mem_allowin_out} !== 3'b100) begin
        errors++; $display("FAIL delay%0d busy/valid/allowin got %b exp 100", c, {mem_fwd_busy_out, mem_valid_out, mem_allowin_out}); end
      step();
    end
    data_data_ok_in = 1'b1; data_rdata_in = 32'hCAFE_F00D;
    #1;
    checks++; if ({mem_fwd_busy_out, mem_valid_out} !== 2'b01) begin errors++; $display("FAIL delay_ok busy/valid got %b exp 01", {mem_fwd_busy_out, mem_valid_out}); end
    checks++; if (mem_wbdata_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL delay_data got %h exp cafef00d", mem_wbdata_out); end
    step();
    data_data_ok_in = 1'b0;
  endtask

  task automatic test_wb_stall();
    wb_allowin_in = 1'b0;
    drive_exe(32'h300, 32'h3000_0000, 4'b1111, 5'd7, 3'd5, 3'd0);
    step();
    idle_exe();
    data_data_ok_in = 1'b1; data_rdata_in = 32'h1122_3344;
    #1;
    checks++; if (mem_valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid got %0h exp 1", mem_valid_out); end
    checks++; if (mem_allowin_out !== 1'b0) begin errors++; $display("FAIL stall_allowin got %0h exp 0", mem_allowin_out); end
    step();
    data_data_ok_in = 1'b0; data_rdata_in = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_wbdata_out !== 32'h1122_3344) begin errors++; $display("FAIL stall_buf got %h exp 11223344", mem_wbdata_out); end
    checks++; if ({mem_valid_out, mem_fwd_busy_out} !== 2'b10) begin errors++; $display("FAIL stall_held valid/busy got %b exp 10", {mem_valid_out, mem_fwd_busy_out}); end
    step();
    wb_allowin_in = 1'b1;
    #1;
    checks++; if (mem_wbdata_out !== 32'h1122_3344) begin errors++; $display("FAIL stall_release got %h exp 11223344", mem_wbdata_out); end
    checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL stall_rel_allowin got %0h exp 1", mem_allowin_out); end
    step();
    data_data_ok_in = 1'b1; data_rdata_in = 32'h5555_AAAA;
    #1;
    checks++; if ({mem_valid_out, mem_fwd_busy_out, mem_reg_we_out, mem_fwd_wnum_out} !== 11'd0) begin
      errors++; $display("FAIL stray_ok got %h exp 0", {mem_valid_out, mem_fwd_busy_out, mem_reg_we_out, mem_fwd_wnum_out}); end
    step();
    data_data_ok_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_allowin_in = 1'b0;
    drive_exe(32'h400, 32'h4000_0000, 4'b1111, 5'd4, 3'd5, 3'd0);
    step();
    idle_exe();
    data_data_ok_in = 1'b1; data_rdata_in = 32'h0BAD_0BAD;
    step();
    data_data_ok_in = 1'b0; data_rdata_in = 32'd0; wb_allowin_in = 1'b1;
    drive_exe(32'h404, 32'h4000_0002, 4'b1111, 5'd9, 3'd3, 3'd0);
    #1;
    checks++; if (mem_allowin_out !== 1'b1) begin errors++; $display("FAIL b2b_allowin got %0h exp 1", mem_allowin_out); end
    step();
    idle_exe();
    #1;
    checks++; if ({mem_fwd_busy_out, mem_valid_out} !== 2'b10) begin errors++; $display("FAIL b2b_got_cleared busy/valid got %b exp 10", {mem_fwd_busy_out, mem_valid_out}); end
    checks++; if (mem_fwd_wnum_out !== 5'd9) begin errors++; $display("FAIL b2b_fwd_wnum got %0d exp 9", mem_fwd_wnum_out); end
    data_data_ok_in = 1'b1; data_rdata_in = 32'h8001_0000;
    #1;
    checks++; if (mem_wbdata_out !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_lh got %h exp ffff8001", mem_wbdata_out); end
    checks++; if (mem_PC_out !== 32'h404) begin errors++; $display("FAIL b2b_pc got %h exp 00000404", mem_PC_out); end
    step();
    data_data_ok_in = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    drive_exe(32'h500, 32'h5000_0000, 4'b1111, 5'd20, 3'd5, 3'd1);
    step();
    idle_exe();
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_valid_out, mem_fwd_busy_out, mem_fwd_wnum_out, mem_reg_we_out} !== 11'd0) begin
      errors++; $display("FAIL rstmid_ctl got %h exp 0", {mem_valid_out, mem_fwd_busy_out, mem_fwd_wnum_out, mem_reg_we_out}); end
    checks++; if ({mem_PC_out, mem_wbdata_out, mem_write_type_out} !== 67'd0) begin
      errors++; $display("FAIL rstmid_data got %h exp 0", {mem_PC_out, mem_wbdata_out, mem_write_type_out}); end
    @(negedge clk);
    rst_n = 1'b1;
    data_data_ok_in = 1'b1; data_rdata_in = 32'h7777_7777;
    #1;
    checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_ok_valid got %0h exp 0", mem_valid_out); end
    step();
    data_data_ok_in = 1'b0;
    #1;
    checks++; if (mem_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_after got %0h exp 0", mem_valid_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_align();
    test_load_delay();
    test_wb_stall();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits between the execute stage and the writeback stage. It registers one instruction from EXE and waits for the data-SRAM response on loads. It performs load-data extraction and alignment, including the unaligned LWL/LWR byte-merge enables, and presents write data, byte enables, destination register and PC to WB under a valid/allowin handshake. It also exports a forwarding/hazard view of the instruction it holds.

## Interface
Parameters: none. Widths fixed: 32-bit data, 5-bit register number, 4-bit byte enable.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- exe_valid_in  in  1  EXE holds a valid instruction for MEM
- mem_allowin_out  out  1  MEM accepts an instruction at this edge
- exe_PC_in  in  32  instruction PC
- exe_alures_in  in  32  ALU result; the load address for loads
- exe_reg_we_in  in  4  byte write enables toward the register file
- exe_wnum_in  in  5  destination register
- exe_load_type_in  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- exe_write_type_in  in  3  passed through to WB unchanged
- data_rdata_in  in  32  data-SRAM read data
- data_data_ok_in  in  1  data-SRAM response valid this cycle
- wb_allowin_in  in  1  WB accepts an instruction
- mem_valid_out  out  1  MEM presents a completed instruction to WB
- mem_PC_out  out  32  registered PC
- mem_wbdata_out  out  32  aligned writeback data
- mem_reg_we_out  out  4  final byte enables, gated by mem_valid_out
- mem_wnum_out  out  5  destination register, gated by mem_valid_out
- mem_write_type_out  out  3  registered write type
- mem_fwd_wnum_out  out  5  destination register of the held instruction; 0 when not valid
- mem_fwd_busy_out  out  1  held instruction is a load whose data has not yet arrived (load-use stall)

## Operation
- Pipeline register: valid_r plus all exe_* fields. Loaded at the edge where mem_allowin_out && exe_valid_in.
  - When allowin is high and exe_valid_in is low, valid_r clears.
- ready = (load_type == 0) || got_r || data_data_ok_in.
- mem_allowin_out = !valid_r || (ready && wb_allowin_in).
- mem_valid_out = valid_r && ready.
- Response buffer: rbuf_r (32 bits) and got_r.
  - Set on data_data_ok_in while valid_r, the held instruction is a load, and got_r == 0.
  - Cleared when the instruction leaves MEM (mem_valid_out && wb_allowin_in) or when a new instruction is loaded.
  - Effective rdata = got_r ? rbuf_r : data_rdata_in.
- data_data_ok_in while no load is waiting (valid_r == 0, a non-load, or got_r == 1) is ignored.
- Alignment (a = alures[1:0]):
  - LB/LBU: byte a, sign- or zero-extended; we 1111.
  - LH/LHU: halfword a[1], sign- or zero-extended; we 1111.
  - LW: rdata; we 1111.
  - LWL: data = rdata << (8*(3-a)); we for a = 0/1/2/3 is 1000/1100/1110/1111.
  - LWR: data = rdata >> (8*a); we for a = 0/1/2/3 is 1111/0111/0011/0001.
  - Non-load: data = alures.
- mem_reg_we_out = exe_reg_we field & load mask & {4{mem_valid_out}}.
- mem_wnum_out = wnum field & {5{mem_valid_out}}.
- mem_fwd_busy_out = valid_r && (load_type != 0) && !got_r && !data_data_ok_in.

## Timing
- Reset (async, rst_n = 0) clears valid_r, got_r, rbuf_r, PC, all fields and all outputs to 0. mem_allowin_out is 1 immediately after reset deasserts.
- Reset mid-load discards the pending load. A data_data_ok_in arriving after reset hits an empty stage and is ignored.
- Non-load latency: 1 cycle. Valid to WB in the cycle after capture.
- Load latency: data_data_ok_in in the capture+1 cycle gives mem_valid_out in that same cycle (combinational rdata path). Each later data_ok adds one cycle per cycle of delay.
- data_ok while wb_allowin_in = 0: data is latched into rbuf_r, the instruction stays valid, and later rdata changes are not observed.
- Simultaneous leave and enter: the new instruction overwrites the register, and got_r is cleared at the same edge.
- A bubble is never presented: mem_reg_we_out and mem_wnum_out are 0 whenever mem_valid_out = 0.

## Test plan
- ADD (load_type 0), alures 0x12345678, we 1111, wnum 5 -> next cycle mem_valid_out = 1, wbdata 0x12345678, we 1111, wnum 5.
- LB at addr 0x...01, data_ok in capture+1 with rdata 0x0080FF00 -> same cycle wbdata 0xFFFFFFFF, we 1111. LBU at the same address -> 0x000000FF.
- LWL at addr 0x...01, rdata 0xAABBCCDD -> wbdata 0xCCDD0000, we 1100. LWR at addr 0x...02 -> wbdata 0x0000AABB, we 0011.
- LW with data_ok delayed 3 cycles -> mem_fwd_busy_out = 1 and mem_valid_out = 0 for 3 cycles, allowin = 0. Valid, with busy = 0, in the ok cycle.
- LW, data_ok while wb_allowin_in = 0, then rdata changes -> the buffered value is delivered when wb_allowin_in rises. A stray data_ok with the stage empty -> no output change.
- rst_n pulled low while a load is waiting -> all outputs 0 immediately. A following data_ok -> mem_valid_out stays 0.
